// File: rtl/keccak_lane_buffer.sv
// keccak_lane_buffer
//   Holds the 1600-bit Keccak state between the XIF issue/result controller
//   and the Keccak-f[1600] permutation core. Accepts 64-bit lane writes built
//   from two 32-bit operands, launches the permutation, captures the permuted
//   state, and returns 32-bit words for write-back.
//
// Build option:
//   KECCAK_LANE_BUF_ABSORB_EN  defined: a load XORs the operand pair into the
//                              existing lane (sponge absorb).
//                              undefined: a load overwrites the lane.
//
// Ports:
//   clk_i, rst_ni       clock (rising edge), async active-low reset
//   clear_i             zero the buffer and the error flag; aborts a permutation
//   load_i, lane_idx_i  write lane lane_idx_i with {lane_hi_i, lane_lo_i}
//   start_i             request a permutation
//   rd_i, rd_idx_i      read 32-bit word rd_idx_i (2k = lane k low, 2k+1 = high)
//   rd_data_o           registered read data, held while rd_i=0
//   busy_o              permutation in flight (LAUNCH or WAIT)
//   done_o              one-cycle pulse once the permuted state is captured
//   err_o               sticky protocol error
//   perm_start_o        one-cycle start pulse to the core
//   perm_state_o        direct view of the buffer, lane k at [64k+63:64k]
//   perm_done_i         core completion strobe, perm_state_i valid this cycle
//   perm_state_i        permuted state from the core

module keccak_lane_buffer #(
  parameter int XLEN   = 32,
  parameter int NLANES = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [4:0]            lane_idx_i,
  input  logic [XLEN-1:0]       lane_lo_i,
  input  logic [XLEN-1:0]       lane_hi_i,
  input  logic                  start_i,
  input  logic                  rd_i,
  input  logic [5:0]            rd_idx_i,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  perm_start_o,
  output logic [64*NLANES-1:0]  perm_state_o,
  input  logic                  perm_done_i,
  input  logic [64*NLANES-1:0]  perm_state_i
);

  localparam int NWORDS = 2 * NLANES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

  state_e                  state_q, state_d;
  logic [NLANES-1:0][63:0] lanes_q;
  // Set when a clear abandons a permutation the core has already accepted;
  // the late perm_done_i from that run is then swallowed without an error.
  logic                    orphan_q;

  logic        busy;
  logic        lane_ok, rd_ok;
  logic [4:0]  lane_sel, rd_lane_sel;
  logic        load_en, capture, err_set;
  logic [63:0] new_lane;
  logic [31:0] rd_word;

  assign busy     = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign lane_ok  = lane_idx_i < 5'(NLANES);
  assign rd_ok    = rd_idx_i < 6'(NWORDS);
  // Clamp indices so out-of-range requests never address past the array.
  assign lane_sel    = lane_ok ? lane_idx_i : '0;
  assign rd_lane_sel = rd_ok ? rd_idx_i[5:1] : '0;

  assign load_en = load_i && !clear_i && !busy && lane_ok;
  assign capture = perm_done_i && !clear_i && (state_q == ST_WAIT);

  // clear_i wins over everything in its cycle, including error reporting.
  assign err_set = !clear_i &&
                   ((load_i && (!lane_ok || busy)) ||
                    (start_i && (state_q != ST_IDLE)) ||
                    (perm_done_i && (state_q != ST_WAIT) && !orphan_q) ||
                    (rd_i && !rd_ok));

`ifdef KECCAK_LANE_BUF_ABSORB_EN
  assign new_lane = lanes_q[lane_sel] ^ {lane_hi_i, lane_lo_i};
`else
  assign new_lane = {lane_hi_i, lane_lo_i};
`endif

  assign rd_word = rd_idx_i[0] ? lanes_q[rd_lane_sel][63:32]
                               : lanes_q[rd_lane_sel][31:0];

  assign perm_state_o = lanes_q;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_LAUNCH;
      ST_LAUNCH:  state_d = ST_WAIT;
      ST_WAIT:    if (perm_done_i) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (clear_i) state_d = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      perm_start_o <= 1'b0;
      err_o        <= 1'b0;
      orphan_q     <= 1'b0;
      rd_data_o    <= '0;
    end else begin
      state_q      <= state_d;
      // Status outputs are registered from the next state so they line up
      // exactly with the state they describe.
      busy_o       <= (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
      done_o       <= (state_d == ST_CAPTURE);
      perm_start_o <= (state_d == ST_LAUNCH);

      if (clear_i)      err_o <= 1'b0;
      else if (err_set) err_o <= 1'b1;

      if (clear_i && busy && !(state_q == ST_WAIT && perm_done_i)) orphan_q <= 1'b1;
      else if (perm_done_i)                                        orphan_q <= 1'b0;

      if (rd_i) rd_data_o <= rd_ok ? rd_word : '0;
    end
  end

  // NOTE: the state buffer is reset because the controller relies on an
  // all-zero state after reset; it is a flop array, not a RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lanes_q <= '0;
    end else if (clear_i) begin
      lanes_q <= '0;
    end else if (capture) begin
      lanes_q <= perm_state_i;
    end else if (load_en) begin
      lanes_q[lane_sel] <= new_lane;
    end
  end

endmodule

// File: tb/tb_keccak_lane_buffer.sv
// tb_keccak_lane_buffer
//   Self-checking bench for keccak_lane_buffer. Read data goes through a
//   scoreboard: each issued read pushes its expected word, and a monitor pops
//   and compares one cycle later. Control outputs are checked inline.
//   Honours KECCAK_LANE_BUF_ABSORB_EN for the absorb-mode expectation.

module tb_keccak_lane_buffer;

  localparam logic [1599:0] PAT_A5 = {25{64'hA5A5A5A5A5A5A5A5}};
  localparam logic [1599:0] PAT_B  = {25{64'h0123456789ABCDEF}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [4:0]    lane_idx = '0;
  logic [31:0]   lane_lo = '0;
  logic [31:0]   lane_hi = '0;
  logic          start = 1'b0;
  logic          rd = 1'b0;
  logic [5:0]    rd_idx = '0;
  logic [31:0]   rd_data;
  logic          busy, done, err, perm_start;
  logic [1599:0] perm_state_out;
  logic          perm_done = 1'b0;
  logic [1599:0] perm_state_in = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  keccak_lane_buffer #(.XLEN(32), .NLANES(25)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .load_i       (load),
    .lane_idx_i   (lane_idx),
    .lane_lo_i    (lane_lo),
    .lane_hi_i    (lane_hi),
    .start_i      (start),
    .rd_i         (rd),
    .rd_idx_i     (rd_idx),
    .rd_data_o    (rd_data),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .perm_start_o (perm_start),
    .perm_state_o (perm_state_out),
    .perm_done_i  (perm_done),
    .perm_state_i (perm_state_in)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards apply to the next edge and
  // outputs read afterwards reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input int idx, input logic [31:0] exp);
    rd     = 1'b1;
    rd_idx = 6'(idx);
    exp_q.push_back(exp);
    step();
    rd = 1'b0;
  endtask

  task automatic load_lane(input int idx, input logic [31:0] lo, input logic [31:0] hi);
    load     = 1'b1;
    lane_idx = 5'(idx);
    lane_lo  = lo;
    lane_hi  = hi;
    step();
    load = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Read-data monitor: a read sampled at an edge presents data after it.
  initial begin
    logic r;
    forever begin
      @(posedge clk);
      r = rd;
      #1;
      if (r && rst_n) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got %h with no expected entry", rd_data);
        end else begin
          check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int busy_cnt, start_cnt, done_cnt;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_perm_start", 64'(perm_start), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_state_zero", 64'(perm_state_out == '0), 64'd1);
    for (int i = 0; i < 50; i++) read_word(i, 32'h0);
    check("reset_err_after_reads", 64'(err), 64'd0);
    check("reset_busy_after_reads", 64'(busy), 64'd0);

    // ---------------- lane load / read ----------------
    load_lane(3, 32'hDEADBEEF, 32'h01234567);
    read_word(6, 32'hDEADBEEF);
    read_word(7, 32'h01234567);
    step();
    check("rd_hold", 64'(rd_data), 64'h01234567);
    check("lane3_view", perm_state_out[255:192], 64'h01234567DEADBEEF);
    load_lane(3, 32'hDEADBEEF, 32'h01234567);
`ifdef KECCAK_LANE_BUF_ABSORB_EN
    read_word(6, 32'h0);
`else
    read_word(6, 32'hDEADBEEF);
`endif

    // ---------------- permutation round trip ----------------
    load_lane(0, 32'h11111111, 32'h22222222);
    start = 1'b1;
    step();
    start = 1'b0;
    check("launch_perm_start", 64'(perm_start), 64'd1);
    check("launch_busy", 64'(busy), 64'd1);
    check("launch_lane0", perm_state_out[63:0], 64'h2222222211111111);
    busy_cnt = 0; start_cnt = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 28; cyc++) begin
      busy_cnt  += int'(busy);
      start_cnt += int'(perm_start);
      done_cnt  += int'(done);
      if (cyc == 24) begin
        perm_done     = 1'b1;
        perm_state_in = PAT_A5;
      end else begin
        perm_done = 1'b0;
      end
      step();
    end
    perm_done = 1'b0;
    check("perm_busy_cycles", 64'(busy_cnt), 64'd25);
    check("perm_start_pulses", 64'(start_cnt), 64'd1);
    check("perm_done_pulses", 64'(done_cnt), 64'd1);
    check("perm_err", 64'(err), 64'd0);
    read_word(0, 32'hA5A5A5A5);
    read_word(49, 32'hA5A5A5A5);

    // ---------------- error: lane index 25 ----------------
    load_lane(25, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("bad_lane_err", 64'(err), 64'd1);
    check("bad_lane_unchanged", 64'(perm_state_out == PAT_A5), 64'd1);
    read_word(0, 32'hA5A5A5A5);
    do_clear();
    check("clear_err", 64'(err), 64'd0);
    check("clear_state_zero", 64'(perm_state_out == '0), 64'd1);

    // ---------------- error: read index 50 ----------------
    load_lane(5, 32'h13579BDF, 32'h2468ACE0);
    read_word(10, 32'h13579BDF);
    check("good_read_no_err", 64'(err), 64'd0);
    read_word(50, 32'h0);
    check("bad_read_err", 64'(err), 64'd1);
    do_clear();

    // ---------------- error: perm_done outside WAIT ----------------
    perm_done = 1'b1;
    step();
    perm_done = 1'b0;
    check("stray_done_err", 64'(err), 64'd1);
    check("stray_done_no_done", 64'(done), 64'd0);
    do_clear();
    check("stray_done_cleared", 64'(err), 64'd0);

    // ---------------- start/load during busy, clear in WAIT ----------------
    load_lane(2, 32'h0000BEEF, 32'h0);
    start = 1'b1;
    step();                     // LAUNCH
    check("second_start_pulse", 64'(perm_start), 64'd1);
    step();                     // start still high: rejected in LAUNCH
    start = 1'b0;
    check("start_busy_err", 64'(err), 64'd1);
    check("start_busy_still_busy", 64'(busy), 64'd1);
    check("start_busy_no_repulse", 64'(perm_start), 64'd0);
    load_lane(1, 32'h1, 32'h2);
    read_word(4, 32'h0000BEEF);  // pre-permutation contents during busy
    read_word(2, 32'h0);         // dropped load left lane 1 at zero
    do_clear();
    check("abort_err", 64'(err), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    perm_done     = 1'b1;
    perm_state_in = PAT_A5;
    step();
    perm_done = 1'b0;
    check("orphan_no_done", 64'(done), 64'd0);
    check("orphan_no_err", 64'(err), 64'd0);
    check("orphan_state_zero", 64'(perm_state_out == '0), 64'd1);
    step();
    check("orphan_no_done_late", 64'(done), 64'd0);
    check("orphan_idle", 64'(busy), 64'd0);
    read_word(0, 32'h0);

    // ---------------- same-cycle load + start, back-to-back ----------------
    load     = 1'b1;
    lane_idx = 5'd24;
    lane_lo  = 32'hCAFEF00D;
    lane_hi  = 32'h0BADC0DE;
    start    = 1'b1;
    step();
    load  = 1'b0;
    start = 1'b0;
    check("ls_perm_start", 64'(perm_start), 64'd1);
    check("ls_lane24", perm_state_out[1599:1536], 64'h0BADC0DECAFEF00D);
    step();                     // WAIT
    check("ls_wait_no_start", 64'(perm_start), 64'd0);
    perm_done     = 1'b1;
    perm_state_in = PAT_B;
    step();                     // CAPTURE
    perm_done = 1'b0;
    check("ls_done", 64'(done), 64'd1);
    check("ls_done_busy", 64'(busy), 64'd0);
    check("ls_done_err", 64'(err), 64'd0);
    start = 1'b1;               // start in the done cycle: rejected
    read_word(49, 32'h01234567);
    start = 1'b0;
    check("b2b_reject_err", 64'(err), 64'd1);
    check("b2b_reject_no_start", 64'(perm_start), 64'd0);
    check("b2b_reject_no_busy", 64'(busy), 64'd0);
    check("b2b_done_single", 64'(done), 64'd0);
    start = 1'b1;               // cycle after done: accepted
    step();
    start = 1'b0;
    check("b2b_accept_start", 64'(perm_start), 64'd1);
    do_clear();
    check("final_clear_err", 64'(err), 64'd0);
    check("final_clear_busy", 64'(busy), 64'd0);
    read_word(48, 32'h0);

    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keccak_lane_buffer.md
# keccak_lane_buffer

Holds the 1600-bit Keccak state between the XIF issue/result controller and the Keccak-f[1600] permutation core. It accepts 64-bit lane writes built from two 32-bit source operands, launches the permutation, captures the permuted state, and returns 32-bit words for write-back. The controller's start, store and done handshakes terminate here.

## Interface
Parameters:
- XLEN, 32, operand and read-data width; only 32 is supported.
- NLANES, 25, number of 64-bit lanes.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  zero the whole buffer and the error flag.
- load_i  in  1  write one lane this cycle.
- lane_idx_i  in  5  lane index for load_i, 0..24.
- lane_lo_i  in  32  lane bits [31:0] (rs1).
- lane_hi_i  in  32  lane bits [63:32] (rs2).
- start_i  in  1  request a permutation (controller keccak_start).
- rd_i  in  1  read request (controller keccak_store).
- rd_idx_i  in  6  32-bit word index, 0..49; word 2k is lane k low, word 2k+1 is lane k high.
- rd_data_o  out  32  read data.
- busy_o  out  1  permutation in flight.
- done_o  out  1  one-cycle pulse when the permuted state has been captured.
- err_o  out  1  sticky protocol error.
- perm_start_o  out  1  one-cycle start pulse to the core.
- perm_state_o  out  1600  buffer contents presented to the core; lane k at bits [64k+63:64k].
- perm_done_i  in  1  core completion strobe; perm_state_i is valid in this cycle.
- perm_state_i  in  1600  permuted state from the core.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE. Reset state is IDLE.
- IDLE: a start_i goes to LAUNCH. In LAUNCH, perm_start_o=1 for one cycle, then the FSM goes to WAIT. In WAIT, a perm_done_i latches perm_state_i into the buffer and the FSM goes to CAPTURE. In CAPTURE, done_o=1 for one cycle, then the FSM returns to IDLE.
- busy_o=1 in LAUNCH and in WAIT. It is 0 in IDLE and in CAPTURE.
- Load in IDLE or CAPTURE: lane[lane_idx_i] <= {lane_hi_i, lane_lo_i}.
- lane_idx_i>24: the write is dropped and err_o is set.
- Load while busy_o=1: dropped, err_o set.
- start_i while not in IDLE: ignored, err_o set.
- perm_done_i outside WAIT: ignored, err_o set.
- Read: rd_data_o <= selected word on the cycle rd_i=1. rd_idx_i>49 returns 0 and sets err_o. rd_data_o holds its value while rd_i=0. A read is allowed in any state; during busy it returns the pre-permutation contents.
- clear_i: the buffer and err_o become 0 next cycle. If in WAIT, the FSM moves to IDLE and the pending perm_done_i is ignored (not an error). No perm_start_o pulse follows a clear.
- Simultaneous load_i and start_i in IDLE: the load is committed first. perm_state_o in LAUNCH includes that lane.
- Simultaneous clear_i and load_i/start_i: clear wins; the load and start are dropped with no error.
- perm_state_o is a direct view of the buffer. The core must sample it on perm_start_o.

## Timing
- Reset values: buffer 0, rd_data_o 0, busy_o 0, done_o 0, err_o 0, perm_start_o 0, FSM in IDLE.
- Load-to-visible: a lane written at edge N is readable with rd_i at N+1 and returns data at N+2.
- Read latency: 1 cycle, registered.
- start_i at cycle N gives perm_start_o at N+1 and busy_o=1 from N+1.
- perm_done_i at cycle M gives the buffer updated and done_o=1 at M+1, busy_o=0 at M+1, and the FSM in IDLE at M+2.
- Back-to-back: start_i in the done_o cycle is rejected (error). The earliest accepted start is the cycle after done_o.
- All outputs are registered except perm_state_o.

## Configuration
- KECCAK_LANE_BUF_ABSORB_EN defined: a load XORs {lane_hi_i, lane_lo_i} into the existing lane (sponge absorb).
- Undefined: a load overwrites the lane.
- Error and FSM behaviour is identical in both builds.

## Test plan
- Reset then read all 50 words: every rd_data_o=0, err_o=0, busy_o=0.
- Load lane 3 with lo=0xDEADBEEF, hi=0x01234567, read word 6 then word 7 -> 0xDEADBEEF then 0x01234567. With ABSORB_EN, a second identical load followed by a read of word 6 -> 0.
- Load lane 0, start_i, model core returns perm_done_i 24 cycles after perm_start_o with lane0=0xA5A5... -> perm_start_o exactly one cycle, busy_o high for 25 cycles, done_o one cycle, word 0 reads 0xA5A5A5A5.
- Load with lane_idx=25, start during busy, rd_idx=50 -> each drop and set err_o, buffer unchanged, rd_data_o=0; clear_i then returns err_o to 0.
- clear_i during WAIT, then perm_done_i -> FSM in IDLE, no done_o, buffer all zero, err_o=0.
- Same-cycle load(lane 24) and start_i -> perm_state_o[1599:1536] holds the new lane in the perm_start_o cycle.
